queue_pattern_counter: RTL and testbench

//  Downstream consumer of the 2-bit symbol queue. On start, rewinds the queue
//  (rst_front), dequeues symbols until finish, slides them through a window, and

---
 rtl/queue_pattern_counter_pkg.sv | 10 +
 rtl/queue_pattern_counter_if.sv | 10 +
 rtl/queue_pattern_counter_symbol_window.sv | 51 +++++
 rtl/queue_pattern_counter.sv | 72 +++++++
 tb/tb_queue_pattern_counter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/queue_pattern_counter_pkg.sv
// Shared constants for the queue pattern counter: symbol width and FSM state encoding.
package qpc_pkg;
  localparam int SYM_W = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REWIND  = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
endpackage

// File: rtl/queue_pattern_counter_if.sv
// Symbol queue read port: the counter (master) issues rewind/dequeue and reads data/finish.
interface queue_pattern_counter_if;
  logic [qpc_pkg::SYM_W-1:0] q_data;
  logic                      q_finish;
  logic                      q_dequeue;
  logic                      q_rst_front;

  modport master (input q_data, input q_finish, output q_dequeue, output q_rst_front);
  modport slave  (output q_data, output q_finish, input q_dequeue, input q_rst_front);
endinterface

// File: rtl/queue_pattern_counter_symbol_window.sv
// Sliding symbol window with fill counter; hit is combinational on the post-shift window.
// MATCH_OVERLAP_EN keeps fill after a hit, otherwise fill restarts so matches never overlap.
module symbol_window
  import qpc_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic                       clear,
  input  logic [SYM_W-1:0]           sym,
  input  logic [SYM_W*MAX_LEN-1:0]   pattern,
  input  logic [3:0]                 len,
  output logic                       hit
);
  localparam int W = SYM_W * MAX_LEN;
  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

  logic [W-1:0] window, window_next, mask;
  logic [3:0]   fill, fill_next;
  logic         len_ok;

  always_comb begin
    window_next = {window[W-SYM_W-1:0], sym};
    fill_next   = (fill < len) ? fill + 4'd1 : len;
    len_ok      = (len != 4'd0) && (len <= MAX_LEN_L);
    mask        = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[SYM_W*i +: SYM_W] = (i < int'(len)) ? {SYM_W{1'b1}} : {SYM_W{1'b0}};
    end
    hit = shift_en && len_ok && (fill_next == len) && (((window_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= window_next;
`ifdef MATCH_OVERLAP_EN
      fill   <= fill_next;
`else
      fill   <= hit ? 4'd0 : fill_next;
`endif
    end
  end
endmodule

// File: rtl/queue_pattern_counter.sv
// Rewinds the symbol queue, scans it at 2 cycles/symbol and counts pattern matches (saturating).
// Optional MATCH_OVERLAP_EN counts overlapping matches; start is ignored while busy.
module queue_pattern_counter
  import qpc_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SYM_W*MAX_LEN-1:0]   pattern,
  input  logic [3:0]                 pat_len,
  queue_pattern_counter_if.master    qif,
  output logic [CNT_W-1:0]           match_count,
  output logic                       busy,
  output logic                       done
);
  logic [2:0]                 state;
  logic [SYM_W*MAX_LEN-1:0]   pat_q;
  logic [3:0]                 len_q;
  logic                       accept;
  logic                       hit;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  symbol_window #(.MAX_LEN(MAX_LEN)) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (state == ST_CAPTURE),
    .clear    (accept),
    .sym      (qif.q_data),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      match_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pat_q       <= pattern;
            len_q       <= pat_len;
            match_count <= '0;
            state       <= ST_REWIND;
          end
        end
        ST_REWIND:  state <= ST_FETCH;
        ST_FETCH:   state <= qif.q_finish ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE: begin
          if (hit && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + 1'b1;
          end
          state <= ST_FETCH;
        end
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // q_finish gates dequeue so an exhausted queue is never popped.
  assign qif.q_rst_front = (state == ST_REWIND);
  assign qif.q_dequeue   = (state == ST_FETCH) && !qif.q_finish;
  assign busy            = (state == ST_REWIND) || (state == ST_FETCH) || (state == ST_CAPTURE);
  assign done            = (state == ST_DONE);
endmodule

// File: tb/tb_queue_pattern_counter.sv
// Bench for queue_pattern_counter with a behavioural symbol queue and reference match counter.
module tb_queue_pattern_counter;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pattern;
  logic [3:0]  pat_len;
  logic [8:0]  match_count;
  logic        busy, done;
  logic [7:0]  match_count8;
  logic        busy8, done8;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  queue_pattern_counter_if qif ();
  queue_pattern_counter_if qif8 ();

  queue_pattern_counter dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .pat_len(pat_len),
    .qif(qif.master), .match_count(match_count), .busy(busy), .done(done)
  );

  // Narrow-counter instance runs in lockstep off the same queue to exercise saturation.
  queue_pattern_counter #(.CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .pat_len(pat_len),
    .qif(qif8.master), .match_count(match_count8), .busy(busy8), .done(done8)
  );
  assign qif8.q_data   = qif.q_data;
  assign qif8.q_finish = qif.q_finish;

  // Behavioural queue: data registered on the dequeue edge, finish when front reaches rear.
  logic [1:0] mem [0:299];
  logic [1:0] q_syms [$];
  int rear = 0;
  int front = 0;
  int deq_total = 0;

  always @(posedge clk) begin
    if (qif.q_rst_front) begin
      front <= 0;
    end else if (qif.q_dequeue) begin
      qif.q_data <= mem[front];
      front      <= front + 1;
    end
    if (qif.q_dequeue) deq_total <= deq_total + 1;
  end
  assign qif.q_finish = (front == rear);

  function automatic int ref_count(input int len, input logic [15:0] pat);
    int cnt = 0;
    int i = 0;
    int n = q_syms.size();
    bit ok;
    logic [1:0] ps;
    if (len < 1 || len > 8) return 0;
    while (i + len <= n) begin
      ok = 1'b1;
      for (int k = 0; k < len; k++) begin
        ps = pat[2*(len-1-k) +: 2];
        if (q_syms[i+k] != ps) ok = 1'b0;
      end
      if (ok) begin
        cnt++;
`ifdef MATCH_OVERLAP_EN
        i += 1;
`else
        i += len;
`endif
      end else begin
        i++;
      end
    end
    return cnt;
  endfunction

  task automatic load_queue();
    for (int i = 0; i < q_syms.size(); i++) mem[i] = q_syms[i];
    rear = q_syms.size();
  endtask

  task automatic run_scan(input logic [15:0] pat, input logic [3:0] len, input int limit,
                          output int deqs, output int cycles);
    int d0;
    bit both_high = 1'b0;
    @(negedge clk);
    pattern = pat;
    pat_len = len;
    start   = 1'b1;
    d0      = deq_total;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < limit) begin
      if (qif.q_dequeue && qif.q_rst_front) both_high = 1'b1;
      @(negedge clk);
      cycles++;
    end
    deqs = deq_total - d0;
    checks++;
    if (!done) $display("FAIL scan_timeout: done=%0b after %0d cycles, required 1", done, cycles);
    else passed++;
    checks++;
    if (both_high) $display("FAIL dequeue_rewind_exclusive: both high seen, required never");
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; pattern = '0; pat_len = '0;
    #2;
    checks++; if (match_count !== 9'd0) $display("FAIL reset_count: got %0d, required 0", match_count); else passed++;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b, required 00", {busy, done}); else passed++;
    checks++; if ({qif.q_dequeue, qif.q_rst_front} !== 2'b00)
      $display("FAIL reset_queue_ctrl: got %b, required 00", {qif.q_dequeue, qif.q_rst_front}); else passed++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%0b, required 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_capture();
    int n, front_snap, deq_snap;
    q_syms.delete();
    for (int i = 0; i < 8; i++) q_syms.push_back(2'd1);
    load_queue();
    @(negedge clk); pattern = 16'h0001; pat_len = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(qif.q_dequeue && front >= 2) && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    front_snap = front; deq_snap = deq_total;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL midscan_reset_state: busy/done=%b, required 00", {busy, done}); else passed++;
    checks++; if (match_count !== 9'd0) $display("FAIL midscan_reset_count: got %0d, required 0", match_count); else passed++;
    checks++; if ({qif.q_dequeue, qif.q_rst_front} !== 2'b00)
      $display("FAIL midscan_reset_ctrl: got %b, required 00", {qif.q_dequeue, qif.q_rst_front}); else passed++;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL midscan_idle: busy=%0b, required 0", busy); else passed++;
    checks++; if (deq_total - deq_snap !== 0)
      $display("FAIL midscan_no_dequeue: %0d dequeues, required 0", deq_total - deq_snap); else passed++;
    checks++; if (front !== front_snap) $display("FAIL midscan_front_kept: front=%0d, required %0d", front, front_snap); else passed++;
  endtask

  task automatic test_empty();
    int d0;
    q_syms.delete(); load_queue();
    @(negedge clk); pattern = 16'h0000; pat_len = 4'd1; start = 1'b1; d0 = deq_total;
    @(negedge clk); start = 1'b0;
    checks++; if ({qif.q_rst_front, busy} !== 2'b11)
      $display("FAIL empty_rewind: rst_front/busy=%b, required 11", {qif.q_rst_front, busy}); else passed++;
    @(negedge clk);
    checks++; if ({qif.q_rst_front, qif.q_dequeue, done} !== 3'b000)
      $display("FAIL empty_fetch: rst_front/dequeue/done=%b, required 000", {qif.q_rst_front, qif.q_dequeue, done}); else passed++;
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b10) $display("FAIL empty_done_cycle3: done/busy=%b, required 10", {done, busy}); else passed++;
    checks++; if (match_count !== 9'd0) $display("FAIL empty_count: got %0d, required 0", match_count); else passed++;
    checks++; if (deq_total - d0 !== 0) $display("FAIL empty_dequeues: got %0d, required 0", deq_total - d0); else passed++;
  endtask

  task automatic test_basic();
    int deqs, cyc;
    q_syms = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    load_queue();
    run_scan(16'h0006, 4'd2, 40, deqs, cyc);
    checks++; if (match_count !== 9'd2) $display("FAIL basic_count: got %0d, required 2", match_count); else passed++;
    checks++; if (deqs !== 6) $display("FAIL basic_dequeues: got %0d, required 6", deqs); else passed++;
  endtask

  task automatic test_overlap();
    int deqs, cyc, exp;
`ifdef MATCH_OVERLAP_EN
    exp = 3;
`else
    exp = 2;
`endif
    q_syms = '{2'd3, 2'd3, 2'd3, 2'd3};
    load_queue();
    run_scan(16'h000F, 4'd2, 30, deqs, cyc);
    checks++; if (match_count !== 9'(exp)) $display("FAIL overlap_count: got %0d, required %0d", match_count, exp); else passed++;
  endtask

  task automatic test_illegal_len();
    int deqs, cyc;
    logic [3:0] lens [2];
    lens[0] = 4'd0; lens[1] = 4'd9;
    q_syms = '{2'd0, 2'd0, 2'd0, 2'd0};
    load_queue();
    for (int j = 0; j < 2; j++) begin
      run_scan(16'h0000, lens[j], 30, deqs, cyc);
      checks++; if (match_count !== 9'd0) $display("FAIL illegal_len%0d_count: got %0d, required 0", lens[j], match_count); else passed++;
      checks++; if (deqs !== 4) $display("FAIL illegal_len%0d_dequeues: got %0d, required 4", lens[j], deqs); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int deqs, cyc, first, exp;
    q_syms.delete();
    for (int i = 0; i < 24; i++) q_syms.push_back(2'($urandom_range(0, 1)));
    load_queue();
    exp = ref_count(2, 16'h0001);
    run_scan(16'h0001, 4'd2, 80, deqs, cyc);
    first = int'(match_count);
    checks++; if (first !== exp) $display("FAIL b2b_first: got %0d, required %0d", first, exp); else passed++;
    run_scan(16'h0001, 4'd2, 80, deqs, cyc);
    checks++; if (int'(match_count) !== exp) $display("FAIL b2b_replay: got %0d, required %0d", match_count, exp); else passed++;

    q_syms.delete();
    for (int i = 0; i < 256; i++) q_syms.push_back(2'd0);
    load_queue();
    run_scan(16'h0000, 4'd1, 540, deqs, cyc);
    checks++; if (match_count !== 9'd256) $display("FAIL full_queue_count: got %0d, required 256", match_count); else passed++;
    checks++; if (match_count8 !== 8'd255) $display("FAIL saturate_count: got %0d, required 255", match_count8); else passed++;
    checks++; if (deqs !== 256) $display("FAIL full_queue_dequeues: got %0d, required 256", deqs); else passed++;
  endtask

  task automatic test_random();
    int deqs, cyc, n, len, exp;
    logic [15:0] pat;
    for (int it = 0; it < 10; it++) begin
      n   = $urandom_range(0, 40);
      len = $urandom_range(1, 4);
      pat = 16'($urandom);
      q_syms.delete();
      for (int i = 0; i < n; i++)
        q_syms.push_back((it % 2 == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)));
      load_queue();
      exp = ref_count(len, pat);
      run_scan(pat, 4'(len), 2 * n + 12, deqs, cyc);
      checks++; if (int'(match_count) !== exp)
        $display("FAIL random%0d_count: got %0d, required %0d (n=%0d len=%0d)", it, match_count, exp, n, len); else passed++;
      checks++; if (deqs !== n) $display("FAIL random%0d_dequeues: got %0d, required %0d", it, deqs, n); else passed++;
      checks++; if (int'(match_count8) !== ((exp > 255) ? 255 : exp))
        $display("FAIL random%0d_narrow_count: got %0d, required %0d", it, match_count8, exp); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_capture();
    test_empty();
    test_basic();
    test_overlap();
    test_illegal_len();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
